// File: rtl/csa_mul_seq.sv
// csa_mul_seq: digit-serial carry-save multiplier, D bits per cycle, valid/ready product; define CSA_EARLY_EXIT_EN to stop after the last nonzero multiplier digit
module csa_mul_seq #(
    parameter int W = 12,
    parameter int D = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   p,
    output logic             busy
);
    localparam int NDIG = W / D;
    localparam int CW = $clog2(NDIG + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

    generate
        if (W % D != 0) begin : g_bad_d
            $error("W must be a multiple of D");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACC, RESOLVE, DONE} state_t;

    state_t          state;
    logic [W-1:0]    a_r, b_r;
    logic [2*W-1:0]  s_r, c_r, s_n, c_n, pp, t;
    logic [CW-1:0]   cnt;
    logic [D-1:0]    dig;
    logic            last_dig;

    assign dig = D'(b_r >> (int'(cnt) * D));

`ifdef CSA_EARLY_EXIT_EN
    assign last_dig = (b_r >> ((int'(cnt) + 1) * D)) == '0;
`else
    assign last_dig = cnt == LAST_CNT;
`endif

    // fold the current digit's D partial products into the sum/carry rows
    always_comb begin
        s_n = s_r;
        c_n = c_r;
        pp = '0;
        t = '0;
        for (int j = 0; j < D; j++) begin
            pp = {{W{1'b0}}, a_r & {W{dig[j]}}} << (int'(cnt) * D + j);
            t = s_n ^ c_n ^ pp;
            c_n = ((s_n & c_n) | (s_n & pp) | (c_n & pp)) << 1;
            s_n = t;
        end
    end

    // sequencer with registered handshake outputs and the final carry-propagate add
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
            p <= '0;
            busy <= 1'b0;
            a_r <= '0;
            b_r <= '0;
            s_r <= '0;
            c_r <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r <= a;
                    b_r <= b;
                    s_r <= '0;
                    c_r <= '0;
                    cnt <= '0;
                    in_ready <= 1'b0;
                    busy <= 1'b1;
                    state <= ACC;
                end
                ACC: begin
                    s_r <= s_n;
                    c_r <= c_n;
                    cnt <= cnt + 1'b1;
                    state <= last_dig ? RESOLVE : ACC;
                end
                RESOLVE: begin
                    p <= s_r + c_r;
                    out_valid <= 1'b1;
                    state <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready <= 1'b1;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csa_mul_seq.sv
// tb_csa_mul_seq: directed and random products against plain a*b with latency from the digit count
module tb_csa_mul_seq;
    localparam int W = 12;
    localparam int D = 2;
    localparam int NDIG = W / D;

    logic            clk = 1'b0;
    logic            rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0]    a, b;
    logic [2*W-1:0]  p;
    int              errors = 0;
    int              checks = 0;

    csa_mul_seq #(.W(W), .D(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] bv);
`ifdef CSA_EARLY_EXIT_EN
        int h = 0;
        for (int i = 0; i < NDIG; i++)
            if (((bv >> (i * D)) & ((1 << D) - 1)) != 0) h = i;
        return h + 3;
`else
        return NDIG + 2;
`endif
    endfunction

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int hold);
        int n;
        logic [2*W-1:0] pe;
        pe = (2*W)'(int'(av) * int'(bv));
        check("idle_in_ready", in_ready, 1);
        a = av;
        b = bv;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        n = 1;
        check("busy_after_accept", busy, 1);
        while (!out_valid && n < 40) begin
            check("in_ready_low", in_ready, 0);
            @(negedge clk);
            n++;
        end
        check("latency", n, exp_lat(bv));
        check("product", p, pe);
        check("in_ready_done", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_product", p, pe);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("valid_dropped", out_valid, 0);
        check("busy_idle", busy, 0);
        check("in_ready_back", in_ready, 1);
        check("product_kept", p, pe);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_p", p, 0);
        check("rst_busy", busy, 0);
        run_op(12'd3328, 12'd3328, 0);
        run_op(12'd4095, 12'd4095, 0);
        run_op(12'd1234, 12'd567, 5);
        run_op(12'd0, 12'd4095, 0);
        run_op(12'd4095, 12'd0, 0);
        run_op(12'd4095, 12'd3, 0);
        run_op(12'd123, 12'd2048, 1);
        a = 12'd3000;
        b = 12'd2999;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_p", p, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        run_op(12'd5, 12'd7, 0);
        for (int i = 0; i < 25; i++)
            run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 2)));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
